// File: rtl/sum_serial_ctrl.sv
// -----------------------------------------------------------------------------
// sum_serial_ctrl
//
// Nibble-serial wide adder. A single 4-bit add slice (a + b + cin -> 4-bit
// sum + carry) is stepped over WIDTH/4 cycles to add two WIDTH-bit operands.
// Operands are captured when a start request is accepted in IDLE. One nibble
// is processed per clock in RUN. The full-width result is published in one
// step, together with the final carry, as the FSM enters DONE.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      request; sampled only in IDLE
//   a      in   WIDTH  operand A, captured on the accepting edge
//   b      in   WIDTH  operand B, captured on the accepting edge
//   cin    in   1      carry into nibble 0, captured on the accepting edge
//   busy   out  1      high while the slice sequence is running
//   done   out  1      one-cycle pulse; sum/cout hold the new result
//   sum    out  WIDTH  registered result, held until the next completion
//   cout   out  1      carry out of the top nibble, held with sum
// -----------------------------------------------------------------------------
module sum_serial_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int KW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg, b_reg;
    logic             carry_reg;
    logic [KW-1:0]    k_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;

    // Partial result, one entry per nibble, filled as the slice steps.
    logic [3:0]       partial_reg [NIBBLES];

    logic [3:0]       a_nib [NIBBLES];
    logic [3:0]       b_nib [NIBBLES];
    logic [WIDTH-1:0] final_sum;
    logic [4:0]       slice_res;
    logic             k_last;

    // The one shared 4-bit slice: zero-extended 5-bit add of the current
    // nibble pair and the rippled carry.
    assign slice_res = {1'b0, a_nib[k_reg]} + {1'b0, b_nib[k_reg]} + {4'b0000, carry_reg};
    assign k_last    = (k_reg == KW'(NIBBLES - 1));

    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[gi*4 +: 4];
            assign b_nib[gi] = b_reg[gi*4 +: 4];

            // The top nibble is taken straight from the slice so the
            // published sum includes the nibble processed on the exit edge.
            if (gi == NIBBLES - 1) begin : g_top
                assign final_sum[gi*4 +: 4] = slice_res[3:0];
            end else begin : g_low
                assign final_sum[gi*4 +: 4] = partial_reg[gi];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    partial_reg[gi] <= 4'h0;
                end else if (state_reg == RUN && k_reg == KW'(gi)) begin
                    partial_reg[gi] <= slice_res[3:0];
                end
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (k_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, carry ripple, nibble index and result publication
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            k_reg     <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        k_reg     <= '0;
                    end
                end
                RUN: begin
                    carry_reg <= slice_res[4];
                    if (k_last) begin
                        k_reg    <= '0;
                        // sum/cout change only here, never mid-sequence.
                        sum_reg  <= final_sum;
                        cout_reg <= slice_res[4];
                    end else begin
                        k_reg <= k_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule
